// File: rtl/mrjong_rom_loader.sv
// ROM/DIP download loader for the MrJong core.
// Routes index-0 bytes into four ROM regions via a one-entry write buffer and holds the core until a good image lands.
module mrjong_rom_loader #(
    parameter logic [16:0] IMAGE_SIZE = 17'h0A120,
    parameter logic [7:0]  DIP_INDEX  = 8'd254
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [26:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [14:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic [3:0]  mem_sel,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic [7:0]  dsw,
    output logic        core_hold,
    output logic        load_ok,
    output logic        load_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state;
    logic [16:0] count;
    logic        long_f;
    logic        ovr_f;
    logic        full;
    logic        dl_prev;

    logic        img_wr;
    logic        dip_wr;
    logic        dl_rise;
    logic        stalled;
    logic        in_map;
    logic [14:0] reg_addr;
    logic [3:0]  reg_sel;
    logic        image_good;

    assign img_wr     = ioctl_wr && (ioctl_index == 8'd0) && (state == S_LOAD);
    assign dip_wr     = ioctl_wr && (ioctl_index == DIP_INDEX) && (ioctl_addr == 27'd0);
    assign dl_rise    = ioctl_download && !dl_prev;
    assign stalled    = full && !mem_ack;
    assign in_map     = |reg_sel;
    assign image_good = (count == IMAGE_SIZE) && !long_f && !ovr_f;

    assign ioctl_wait = stalled;
    assign mem_we     = full;
    assign core_hold  = reset || (state != S_IDLE) || !load_ok;

    // Region decode: one-hot select plus region-relative address.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        reg_sel  = 4'b0000;
        reg_addr = ioctl_addr[14:0];
        if (ioctl_addr < 27'h08000) begin
            reg_sel = 4'b0001;
        end else if (ioctl_addr < 27'h0A000) begin
            reg_sel  = 4'b0010;
            reg_addr = 15'(ioctl_addr - 27'h08000);
        end else if (ioctl_addr < 27'h0A020) begin
            reg_sel  = 4'b0100;
            reg_addr = 15'(ioctl_addr - 27'h0A000);
        end else if (ioctl_addr < 27'h0A120) begin
            reg_sel  = 4'b1000;
            reg_addr = 15'(ioctl_addr - 27'h0A020);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= 17'd0;
            long_f   <= 1'b0;
            ovr_f    <= 1'b0;
            full     <= 1'b0;
            // Preset high so a download already in flight at reset release is not seen as a new start.
            dl_prev  <= 1'b1;
            mem_addr <= 15'd0;
            mem_data <= 8'd0;
            mem_sel  <= 4'b0000;
            dsw      <= 8'h00;
            load_ok  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            dl_prev <= ioctl_download;

            if (dip_wr) begin
                dsw <= ioctl_dout;
            end

            // An accepted write empties the buffer unless a new byte refills it below.
            if (mem_ack) begin
                full <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (dl_rise && (ioctl_index == 8'd0)) begin
                        state    <= S_LOAD;
                        count    <= 17'd0;
                        long_f   <= 1'b0;
                        ovr_f    <= 1'b0;
                        load_ok  <= 1'b0;
                        load_err <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (img_wr) begin
                        if (count != 17'h1FFFF) begin
                            count <= count + 17'd1;
                        end
                        if (stalled) begin
                            ovr_f <= 1'b1;
                        end
                        if (!in_map) begin
                            long_f <= 1'b1;
                        end else if (!stalled) begin
                            full     <= 1'b1;
                            mem_addr <= reg_addr;
                            mem_data <= ioctl_dout;
                            mem_sel  <= reg_sel;
                        end
                    end
                    if (!ioctl_download) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (!full) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    load_ok  <= image_good;
                    load_err <= !image_good;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mrjong_rom_loader.sv
// Directed bench for mrjong_rom_loader: image routing, back-pressure, sizing errors, overrun, DIP and reset.
`timescale 1ns/1ps
module tb_mrjong_rom_loader;

    // Condensed image: both ends of CPU and GFX ROM plus every PROM byte, 0x520 strobes in all.
    localparam logic [16:0] TB_SIZE = 17'h00520;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [26:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [14:0] mem_addr;
    logic [7:0]  mem_data;
    logic [3:0]  mem_sel;
    logic        mem_we;
    logic        mem_ack;
    logic [7:0]  dsw;
    logic        core_hold;
    logic        load_ok;
    logic        load_err;

    int checks = 0;
    int errors = 0;

    int n_sel [4] = '{0, 0, 0, 0};
    int n_bad  = 0;
    int n_a025 = 0;
    int b_sel [4] = '{0, 0, 0, 0};
    int b_bad  = 0;
    int b_a025 = 0;
    int n_wait_bad = 0;
    int n_wait_hi  = 0;
    logic [17:0] mon_a;

    mrjong_rom_loader #(.IMAGE_SIZE(TB_SIZE), .DIP_INDEX(8'd254)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_sel        (mem_sel),
        .mem_we         (mem_we),
        .mem_ack        (mem_ack),
        .dsw            (dsw),
        .core_hold      (core_hold),
        .load_ok        (load_ok),
        .load_err       (load_err)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] image_addr(input logic [3:0] sel, input logic [14:0] a);
        case (sel)
            4'b0001: return {3'b000, a};
            4'b0010: return 18'h08000 + {3'b000, a};
            4'b0100: return 18'h0A000 + {3'b000, a};
            4'b1000: return 18'h0A020 + {3'b000, a};
            default: return 18'h3FFFF;
        endcase
    endfunction

    // Stream position -> image address.
    function automatic logic [26:0] addr_of(input int i);
        if (i < 'h100)      return 27'(i);
        else if (i < 'h300) return 27'(32'h7E00 + i);
        else                return 27'(32'h9C00 + i);
    endfunction

    // Tallies every write the target accepts and checks it against the original image byte.
    always @(negedge clk_sys) begin
        if (mem_we === 1'b1 && mem_ack === 1'b1) begin
            mon_a = image_addr(mem_sel, mem_addr);
            case (mem_sel)
                4'b0001: n_sel[0]++;
                4'b0010: n_sel[1]++;
                4'b0100: n_sel[2]++;
                4'b1000: n_sel[3]++;
                default: n_bad++;
            endcase
            if (mon_a >= 18'h0A120 || mem_data !== mon_a[7:0]) n_bad++;
            if (mem_sel == 4'b1000 && mem_addr == 15'h005 && mem_data == 8'h25) n_a025++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic snap();
        for (int k = 0; k < 4; k++) b_sel[k] = n_sel[k];
        b_bad  = n_bad;
        b_a025 = n_a025;
    endtask

    function automatic int writes_since();
        return (n_sel[0] - b_sel[0]) + (n_sel[1] - b_sel[1]) + (n_sel[2] - b_sel[2]) + (n_sel[3] - b_sel[3]);
    endfunction

    task automatic start_download();
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b1;
        tick();
        tick();
    endtask

    // Strobes n bytes, honouring ioctl_wait; bp pulses mem_ack one cycle in four.
    task automatic send_bytes(input int n, input bit bp, output int sent);
        int cyc = 0;
        sent = 0;
        while (sent < n && cyc < 8 * n + 64) begin
            if (bp) mem_ack = (cyc % 4 == 3);
            #1;
            if (ioctl_wait !== (mem_we && !mem_ack)) n_wait_bad++;
            if (ioctl_wait === 1'b1) n_wait_hi++;
            if (ioctl_wait === 1'b0) begin
                ioctl_wr   = 1'b1;
                ioctl_addr = addr_of(sent);
                ioctl_dout = ioctl_addr[7:0];
                sent++;
            end
            tick();
            ioctl_wr = 1'b0;
            cyc++;
        end
    endtask

    task automatic wait_result(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (load_ok === 1'b1 || load_err === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int sent;
        bit seen;

        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_addr     = 27'd0;
        ioctl_dout     = 8'd0;
        mem_ack        = 1'b0;
        tick();
        tick();

        check("rst_ioctl_wait", 32'(ioctl_wait), 32'd0);
        check("rst_mem_we",     32'(mem_we),     32'd0);
        check("rst_mem_sel",    32'(mem_sel),    32'd0);
        check("rst_mem_addr",   32'(mem_addr),   32'd0);
        check("rst_mem_data",   32'(mem_data),   32'd0);
        check("rst_dsw",        32'(dsw),        32'd0);
        check("rst_load_ok",    32'(load_ok),    32'd0);
        check("rst_load_err",   32'(load_err),   32'd0);
        check("rst_core_hold",  32'(core_hold),  32'd1);

        reset = 1'b0;
        tick();
        check("hold_after_reset", 32'(core_hold), 32'd1);

        // DIP byte: accepted without stall, other DIP addresses ignored.
        ioctl_index = 8'd254;
        ioctl_addr  = 27'd0;
        ioctl_dout  = 8'h5A;
        ioctl_wr    = 1'b1;
        #1;
        check("dip_no_wait", 32'(ioctl_wait), 32'd0);
        tick();
        ioctl_wr = 1'b0;
        check("dip_dsw", 32'(dsw), 32'h5A);
        ioctl_addr = 27'd1;
        ioctl_dout = 8'h33;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        check("dip_other_addr", 32'(dsw), 32'h5A);

        // Full image, zero-wait target.
        snap();
        mem_ack = 1'b1;
        start_download();
        send_bytes(int'(TB_SIZE), 1'b0, sent);
        ioctl_download = 1'b0;
        wait_result(seen);
        check("full_result_seen", 32'(seen), 32'd1);
        check("full_cpu_writes",  32'(n_sel[0] - b_sel[0]), 32'h200);
        check("full_gfx_writes",  32'(n_sel[1] - b_sel[1]), 32'h200);
        check("full_col_writes",  32'(n_sel[2] - b_sel[2]), 32'h20);
        check("full_lut_writes",  32'(n_sel[3] - b_sel[3]), 32'h100);
        check("full_a025_routed", 32'(n_a025 - b_a025), 32'd1);
        check("full_bad_writes",  32'(n_bad - b_bad), 32'd0);
        check("full_load_ok",     32'(load_ok), 32'd1);
        check("full_load_err",    32'(load_err), 32'd0);
        check("full_core_hold",   32'(core_hold), 32'd0);

        // Back-pressure: ack one cycle in four.
        snap();
        n_wait_bad = 0;
        n_wait_hi  = 0;
        mem_ack    = 1'b0;
        start_download();
        send_bytes(int'(TB_SIZE), 1'b1, sent);
        check("bp_all_sent", 32'(sent), 32'(TB_SIZE));
        ioctl_download = 1'b0;
        mem_ack        = 1'b1;
        wait_result(seen);
        check("bp_result_seen",  32'(seen), 32'd1);
        check("bp_wait_exact",   32'(n_wait_bad), 32'd0);
        check("bp_wait_seen",    32'(n_wait_hi > 0), 32'd1);
        check("bp_no_loss",      32'(writes_since()), 32'(TB_SIZE));
        check("bp_bad_writes",   32'(n_bad - b_bad), 32'd0);
        check("bp_counter",      32'(dut.count), 32'(TB_SIZE));
        check("bp_load_ok",      32'(load_ok), 32'd1);

        // Short image.
        start_download();
        send_bytes(int'(TB_SIZE) - 32, 1'b0, sent);
        ioctl_download = 1'b0;
        wait_result(seen);
        check("short_load_err",  32'(load_err), 32'd1);
        check("short_load_ok",   32'(load_ok), 32'd0);
        tick();
        tick();
        tick();
        check("short_core_hold", 32'(core_hold), 32'd1);

        // Long image: one byte past the map.
        snap();
        start_download();
        send_bytes(int'(TB_SIZE) + 1, 1'b0, sent);
        check("long_last_not_written", 32'(mem_we), 32'd0);
        ioctl_download = 1'b0;
        wait_result(seen);
        check("long_writes",   32'(writes_since()), 32'(TB_SIZE));
        check("long_bad",      32'(n_bad - b_bad), 32'd0);
        check("long_load_err", 32'(load_err), 32'd1);

        // Overrun: second strobe while the first is still pending.
        snap();
        mem_ack = 1'b0;
        start_download();
        ioctl_addr = 27'h10;
        ioctl_dout = 8'h10;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        check("ovr_wait",    32'(ioctl_wait), 32'd1);
        check("ovr_pending", 32'(mem_we), 32'd1);
        ioctl_addr = 27'h11;
        ioctl_dout = 8'h11;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        check("ovr_first_addr", 32'(mem_addr), 32'h10);
        check("ovr_first_data", 32'(mem_data), 32'h10);
        mem_ack = 1'b1;
        tick();
        check("ovr_second_dropped", 32'(mem_we), 32'd0);
        ioctl_download = 1'b0;
        wait_result(seen);
        check("ovr_writes",   32'(writes_since()), 32'd1);
        check("ovr_load_err", 32'(load_err), 32'd1);
        check("ovr_load_ok",  32'(load_ok), 32'd0);

        // Asynchronous reset mid-download, remainder ignored, then a clean reload.
        mem_ack = 1'b1;
        start_download();
        send_bytes(64, 1'b0, sent);
        check("pre_reset_pending", 32'(mem_we), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("reset_mem_we",    32'(mem_we), 32'd0);
        check("reset_core_hold", 32'(core_hold), 32'd1);
        check("reset_wait",      32'(ioctl_wait), 32'd0);
        reset = 1'b0;
        tick();
        snap();
        send_bytes(16, 1'b0, sent);
        check("remainder_ignored",  32'(writes_since()), 32'd0);
        check("remainder_no_we",    32'(mem_we), 32'd0);
        check("remainder_hold",     32'(core_hold), 32'd1);
        ioctl_download = 1'b0;
        tick();
        tick();
        snap();
        start_download();
        send_bytes(int'(TB_SIZE), 1'b0, sent);
        ioctl_download = 1'b0;
        wait_result(seen);
        check("reload_writes",    32'(writes_since()), 32'(TB_SIZE));
        check("reload_load_ok",   32'(load_ok), 32'd1);
        check("reload_core_hold", 32'(core_hold), 32'd0);
        check("reload_dsw_kept",  32'(dsw), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
